// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the LFSR PRBS generator/checker pair.
// Holds the checker FSM state encoding and the default polynomial
// constants. The generator uses the same constants, so both ends of the
// link agree on the sequence.
package prbs_checker_pkg;

    // Default LFSR: x^10 + x^7 + 1 (feedback from bits 9 and 6)
    localparam int unsigned           PRBS_WIDTH = 10;
    localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS  = 10'h240;
    localparam int unsigned           PRBS_CNT_W = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

endpackage

// File: rtl/prbs_checker_if.sv
// Stream/status bundle for prbs_checker.
//   en        : din valid this cycle
//   din       : received sequence bit
//   clr       : synchronous clear of err_count
//   locked    : reference LFSR synchronised
//   err       : one-cycle mismatch strobe (locked only)
//   err_count : saturating mismatch count
// master drives the stream and reads status; slave is the checker side.
interface prbs_checker_if
    import prbs_checker_pkg::*;
#(
    parameter int unsigned CNT_W = PRBS_CNT_W
);
    logic             en;
    logic             din;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, din, clr,
        input  locked, err, err_count
    );

    modport slave (
        input  en, din, clr,
        output locked, err, err_count
    );
endinterface

// File: rtl/prbs_predict.sv
// Reference-bit prediction and next-shadow selection.
//   shadow_i      : current shadow register, bit 0 newest
//   din_i         : received bit
//   load_din_i    : 1 = shift din in (slaved), 0 = shift prediction in
//   pred_o        : predicted next stream bit, ^(shadow & TAPS)
//   shadow_next_o : shadow after one shift
module prbs_predict
    import prbs_checker_pkg::*;
#(
    parameter int unsigned      WIDTH = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS_TAPS)
) (
    input  logic [WIDTH-1:0] shadow_i,
    input  logic             din_i,
    input  logic             load_din_i,
    output logic             pred_o,
    output logic [WIDTH-1:0] shadow_next_o
);

    always_comb begin
        pred_o        = ^(shadow_i & TAPS);
        shadow_next_o = {shadow_i[WIDTH-2:0], (load_din_i ? din_i : pred_o)};
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker.
// Fills a shadow LFSR from the incoming stream (SEARCH), confirms the
// prediction holds for LOCK_CNT consecutive bits (VERIFY), then free-runs
// the shadow as a reference and counts mismatches (LOCKED). LOSS_CNT
// consecutive mismatches while locked drop back to SEARCH.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : prbs_checker_if.slave (en, din, clr / locked, err, err_count)
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int unsigned      WIDTH    = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRBS_TAPS),
    parameter int unsigned      LOCK_CNT = 16,
    parameter int unsigned      LOSS_CNT = 8,
    parameter int unsigned      CNT_W    = PRBS_CNT_W
) (
    input logic           clk,
    input logic           rst_n,
    prbs_checker_if.slave bus
);

    localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    prbs_state_e        state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               pred;
    logic               load_din;
    logic [WIDTH-1:0]   shadow_next;
    logic               mismatch;

    // Slaved to din until locked; afterwards the shadow free-runs
    assign load_din = (state_q != LOCKED);
    assign mismatch = (bus.din != pred);

    prbs_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .shadow_i      (shadow_q),
        .din_i         (bus.din),
        .load_din_i    (load_din),
        .pred_o        (pred),
        .shadow_next_o (shadow_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            shadow_q    <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;

        if (bus.en) begin
            shadow_d = shadow_next;
            unique case (state_q)
                SEARCH: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    // An all-zero shadow predicts zeros forever; never count it
                    if (!mismatch && (shadow_q != '0)) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                    miss_d  = '0;
                end
            endcase
        end

        // clr overrides a same-cycle increment; err still pulses
        if (bus.clr) begin
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule
